// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: state encoding and length helper shared by the pulse train generator.
package pulse_gen_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // A zero-length phase would make the pulse invisible, so it is stretched to one cycle.
    function automatic int unsigned clamp_min1(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction
endpackage

// File: rtl/pulse_train_generator_phase_timer.sv
// phase_timer: loadable down-counter; Expire marks the last cycle of a loaded phase.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Load,
    input  logic [W-1:0] LoadVal,
    output logic         Expire
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = Load ? LoadVal : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);
    end

    always_ff @(posedge CLK) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign Expire = (cnt_q == W'(1));
endmodule

// File: rtl/pulse_train_generator.sv
// pulse_train_generator: emits NumPulses high pulses of HighLen cycles, each followed
// by a LowLen gap, then a one-cycle Done; all outputs registered.
module pulse_train_generator
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int HI_W  = 4,
    parameter int LO_W  = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [CNT_W-1:0] NumPulses,
    input  logic [HI_W-1:0]  HighLen,
    input  logic [LO_W-1:0]  LowLen,
    output logic             PulseOut,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] PulsesSent
);
    localparam int TW = (HI_W > LO_W) ? HI_W : LO_W;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [HI_W-1:0]  hi_q, hi_d;
    logic [LO_W-1:0]  lo_q, lo_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load;
    logic [TW-1:0]    load_val;
    logic             expire;

    phase_timer #(.W(TW)) u_timer (
        .CLK     (CLK),
        .Reset   (Reset),
        .Load    (load),
        .LoadVal (load_val),
        .Expire  (expire)
    );

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sent_d   = sent_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            IDLE: if (Start) begin
                num_d  = NumPulses;
                hi_d   = HighLen;
                lo_d   = LowLen;
                sent_d = '0;
                if (NumPulses == '0) begin
                    state_d = DONE;
                end else begin
                    state_d  = HIGH;
                    load     = 1'b1;
                    load_val = TW'(clamp_min1(32'(HighLen)));
                end
            end
            HIGH: if (expire) begin
                sent_d   = sent_q + CNT_W'(1);
                state_d  = LOW;
                load     = 1'b1;
                load_val = TW'(clamp_min1(32'(lo_q)));
            end
            LOW: if (expire) begin
                if (sent_q == num_q) begin
                    state_d = DONE;
                end else begin
                    state_d  = HIGH;
                    load     = 1'b1;
                    load_val = TW'(clamp_min1(32'(hi_q)));
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs follow the next state so they line up with the state register (Moore).
        pulse_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sent_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sent_q  <= sent_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign PulseOut   = pulse_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign PulsesSent = sent_q;
endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator: directed checks of pulse shape, Done timing, Start/Reset corner cases.
module tb_pulse_train_generator;
    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] NumPulses = '0;
    logic [3:0] HighLen = '0;
    logic [3:0] LowLen = '0;
    logic       PulseOut, Busy, Done;
    logic [7:0] PulsesSent;

    int total = 0;
    int bad = 0;
    logic [31:0] wave;
    int done_at, ndone, busy_cnt, rises;

    pulse_train_generator dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Start      (Start),
        .NumPulses  (NumPulses),
        .HighLen    (HighLen),
        .LowLen     (LowLen),
        .PulseOut   (PulseOut),
        .Busy       (Busy),
        .Done       (Done),
        .PulsesSent (PulsesSent)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input int n, input int h, input int l, input bit hold);
        NumPulses = 8'(n);
        HighLen   = 4'(h);
        LowLen    = 4'(l);
        Start     = 1'b1;
        tick();
        Start     = hold;
    endtask

    // Samples maxc consecutive cycles starting at the current one; bit c-1 of wave is cycle c.
    task automatic capture(input int maxc);
        logic prev;
        prev = 1'b0;
        wave = '0; done_at = -1; ndone = 0; busy_cnt = 0; rises = 0;
        for (int c = 1; c <= maxc; c++) begin
            wave[c-1] = PulseOut;
            if (PulseOut && !prev) rises++;
            prev = PulseOut;
            if (Busy) busy_cnt++;
            if (Done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (c < maxc) tick();
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pulse", int'(PulseOut), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_sent", int'(PulsesSent), 0);
        Reset = 1'b0;
        tick();

        launch(1, 4, 2, 1'b0);
        chk("t1_busy_lat", int'(Busy), 1);
        capture(8);
        chk("t1_wave", int'(wave), 32'h0F);
        chk("t1_done_at", done_at, 7);
        chk("t1_ndone", ndone, 1);
        chk("t1_busy_cnt", busy_cnt, 7);
        chk("t1_sent", int'(PulsesSent), 1);
        chk("t1_idle_busy", int'(Busy), 0);

        launch(3, 4, 3, 1'b0);
        capture(23);
        chk("t2_wave", int'(wave), 32'h03C78F);
        chk("t2_done_at", done_at, 22);
        chk("t2_ndone", ndone, 1);
        chk("t2_rises", rises, 3);
        chk("t2_sent", int'(PulsesSent), 3);

        launch(0, 4, 2, 1'b0);
        capture(3);
        chk("t3a_wave", int'(wave), 0);
        chk("t3a_done_at", done_at, 1);
        chk("t3a_busy_cnt", busy_cnt, 1);
        chk("t3a_sent", int'(PulsesSent), 0);

        launch(2, 0, 0, 1'b0);
        capture(6);
        chk("t3b_wave", int'(wave), 32'h5);
        chk("t3b_done_at", done_at, 5);
        chk("t3b_sent", int'(PulsesSent), 2);

        launch(2, 4, 2, 1'b0);
        NumPulses = 8'd5; HighLen = 4'd1; LowLen = 4'd1; Start = 1'b1;
        tick();
        Start = 1'b0;
        capture(13);
        chk("t4_wave", int'(wave), 32'h1E7);
        chk("t4_done_at", done_at, 12);
        chk("t4_ndone", ndone, 1);
        chk("t4_sent", int'(PulsesSent), 2);

        launch(4, 3, 2, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("t5_pre_pulse", int'(PulseOut), 1);
        chk("t5_pre_sent", int'(PulsesSent), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t5_rst_pulse", int'(PulseOut), 0);
        chk("t5_rst_busy", int'(Busy), 0);
        chk("t5_rst_done", int'(Done), 0);
        chk("t5_rst_sent", int'(PulsesSent), 0);
        capture(10);
        chk("t5_quiet_wave", int'(wave), 0);
        chk("t5_quiet_ndone", ndone, 0);
        launch(2, 2, 1, 1'b0);
        capture(8);
        chk("t5_fresh_wave", int'(wave), 32'h1B);
        chk("t5_fresh_done_at", done_at, 7);
        chk("t5_fresh_sent", int'(PulsesSent), 2);

        launch(1, 1, 1, 1'b1);
        capture(12);
        chk("t6_wave", int'(wave), 32'h111);
        chk("t6_done_at", done_at, 3);
        chk("t6_ndone", ndone, 3);
        chk("t6_idle_busy", int'(Busy), 0);

        Reset = 1'b1;
        tick();
        chk("t7_rst_wins_busy", int'(Busy), 0);
        chk("t7_rst_wins_pulse", int'(PulseOut), 0);
        Reset = 1'b0;
        Start = 1'b0;
        tick();
        chk("t7_after_busy", int'(Busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
